// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, with round keys fetched
// from an external key store through rk_sel/rk_in.

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, m;
    p = '0;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] b, x2, x3, x12, x15, x240, x252;

  // Inverse affine map first, then multiplicative inverse as b^254 (0 maps to 0).
  always_comb begin
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
    b    = b ^ 8'h05;
    x2   = gmul(b, b);
    x3   = gmul(x2, b);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(x15, x15), gmul(x15, x15));
    x240 = gmul(gmul(x240, x240), gmul(x240, x240));
    x252 = gmul(x240, x12);
    y    = gmul(x252, x2);
  end
endmodule

module aes128_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] ct_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   rk_sel,
  input  logic [127:0] rk_in,
  output logic [127:0] pt_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] isr, isb, ark, imc;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of a block sits at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a  [4];
    logic [7:0]   m2 [4];
    logic [7:0]   m4 [4];
    logic [7:0]   m8 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j]  = s[127 - 8*(4*c + j) -: 8];
        m2[j] = xt(a[j]);
        m4[j] = xt(m2[j]);
        m8[j] = xt(m4[j]);
      end
      // 0e*a[j] ^ 0b*a[j+1] ^ 0d*a[j+2] ^ 09*a[j+3]
      for (int j = 0; j < 4; j++)
        o[127 - 8*(4*c + j) -: 8] =
            (m8[j] ^ m4[j] ^ m2[j]) ^
            (m8[(j+1)%4] ^ m2[(j+1)%4] ^ a[(j+1)%4]) ^
            (m8[(j+2)%4] ^ m4[(j+2)%4] ^ a[(j+2)%4]) ^
            (m8[(j+3)%4] ^ a[(j+3)%4]);
    end
    return o;
  endfunction

  assign isr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (
      .a (isr[127 - 8*i -: 8]),
      .y (isb[127 - 8*i -: 8])
    );
  end

  assign ark = isb ^ rk_in;
  assign imc = inv_mix_columns(ark);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    rk_sel   = cnt_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_sel   = 4'd10;
        if (in_valid) state_d = ROUND;
      end
      ROUND:   if (cnt_q == 4'd1) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      st_q      <= '0;
      pt_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          st_q  <= ct_in ^ rk_in;
          cnt_q <= 4'd9;
        end
        ROUND: begin
          st_q  <= imc;
          cnt_q <= cnt_q - 4'd1;
        end
        FINAL: begin
          pt_out    <= ark;
          out_valid <= 1'b1;
        end
        DONE:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter: FIPS-197 vectors, backpressure, abort
// by reset, ignored input during rounds, back-to-back and random key/ciphertext.

module tb_aes128_decrypt_iter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ct_in, rk_in, pt_out;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]   rk_sel;

  localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ct_in     (ct_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rk_sel    (rk_sel),
    .rk_in     (rk_in),
    .pt_out    (pt_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [127:0] rk_tab [0:10];
  assign rk_in = (rk_sel <= 4'd10) ? rk_tab[rk_sel] : '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- reference model (byte arrays, FIPS-197 inverse cipher) ----
  logic [7:0] fwd_sb [256];
  logic [7:0] inv_sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {fwd_sb[t[31:24]], fwd_sb[t[23:16]], fwd_sb[t[15:8]], fwd_sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, o;
    k = rkey(key, 10);
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) t[row + 4*c] = s[row + 4*((c - row + 4) % 4)];
      k = rkey(key, r);
      for (int i = 0; i < 16; i++) s[i] = inv_sb[t[i]] ^ k[127 - 8*i -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) t[j] = s[4*c + j];
          for (int j = 0; j < 4; j++)
            s[4*c + j] = gm(t[j], 8'h0e) ^ gm(t[(j+1)%4], 8'h0b) ^
                         gm(t[(j+2)%4], 8'h0d) ^ gm(t[(j+3)%4], 8'h09);
        end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic set_key(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) rk_tab[r] = rkey(key, r);
  endtask

  // ---------------- scoreboard / monitor ----------------
  int           cyc = 0;
  logic [127:0] exp_q [$];
  logic [127:0] next_exp;
  int           acc_edge = 0;
  bit           inflight = 0;
  bit           seen_ov  = 0;
  int           n_acc    = 0;
  int           n_pop    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int j;
    if (!rst_n) begin
      inflight = 0;
      seen_ov  = 0;
    end else begin
      chk("busy_vs_in_ready", 128'(busy), 128'(!in_ready));
      if (in_ready) chk("rk_sel_idle", 128'(rk_sel), 128'd10);
      if (inflight && !out_valid) begin
        j = cyc - acc_edge;
        if (j <= 9) chk("rk_sel_round", 128'(rk_sel), 128'(9 - j));
        else begin
          timeout("latency_overrun");
          inflight = 0;
        end
      end
      if (out_valid && !seen_ov) begin
        seen_ov = 1;
        if (inflight) chk("latency", 128'(cyc - acc_edge), 128'd10);
        inflight = 0;
      end
      if (!out_valid) seen_ov = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) timeout("unexpected_output");
        else chk("pt_out", pt_out, exp_q.pop_front());
        n_pop++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(next_exp);
        acc_edge = cyc + 1;
        inflight = 1;
        n_acc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int tgt);
    int k = 0;
    while (n_acc < tgt && k < 100) begin tick(); k++; end
    if (n_acc < tgt) timeout("accept_wait");
  endtask

  task automatic wait_ov();
    int k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    if (!out_valid) timeout("out_valid_wait");
  endtask

  task automatic wait_pop(input int tgt, input bit rnd_ready);
    int k = 0;
    while (n_pop < tgt && k < 300) begin
      tick();
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    if (n_pop < tgt) timeout("output_wait");
    out_ready = 1'b1;
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input bit rnd_ready);
    int a0, p0;
    a0 = n_acc;
    p0 = n_pop;
    set_key(key);
    next_exp = pt;
    ct_in    = ct;
    in_valid = 1'b1;
    wait_acc(a0 + 1);
    in_valid = 1'b0;
    ct_in    = {$urandom, $urandom, $urandom, $urandom};
    wait_pop(p0 + 1, rnd_ready);
  endtask

  initial begin
    logic [127:0] key, ct, held;
    int a1, a2, a0, p0;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_sb[x] = s;
      inv_sb[s] = 8'(x);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ct_in = '0; next_exp = '0;
    set_key(K1);
    chk("model_rk1", rk_tab[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1", model_dec(C1_CT, K1), C1_PT);
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_sel", 128'(rk_sel), 128'd10);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_pt_out", pt_out, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_block(K1, C1_CT, C1_PT, 1'b0);
    run_block(KB, B_CT, B_PT, 1'b0);

    // Backpressure: hold DONE for 5 cycles.
    set_key(K1);
    out_ready = 1'b0;
    p0 = n_pop;
    next_exp = C1_PT; ct_in = C1_CT; in_valid = 1'b1;
    wait_acc(n_acc + 1);
    in_valid = 1'b0;
    wait_ov();
    held = pt_out;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_pt_out", pt_out, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_pt_kept", pt_out, C1_PT);
    if (n_pop != p0 + 1) timeout("bp_pop");

    // Abort by reset with the round counter at 5.
    a0 = n_acc;
    next_exp = C1_PT; ct_in = C1_CT; in_valid = 1'b1;
    wait_acc(a0 + 1);
    in_valid = 1'b0;
    begin
      int k = 0;
      while (rk_sel != 4'd5 && k < 20) begin tick(); k++; end
      if (rk_sel != 4'd5) timeout("rk_sel_5_wait");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_rk_sel", 128'(rk_sel), 128'd10);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_pt_out", pt_out, 128'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_block(K1, C1_CT, C1_PT, 1'b0);

    // in_valid pulses and ct_in noise during rounds must be ignored.
    set_key(K1);
    a0 = n_acc; p0 = n_pop;
    next_exp = C1_PT; ct_in = C1_CT; in_valid = 1'b1;
    wait_acc(a0 + 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      ct_in    = {$urandom, $urandom, $urandom, $urandom};
      next_exp = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    wait_pop(p0 + 1, 1'b0);
    chk("ignore_accepts", 128'(n_acc - a0), 128'd1);

    // Back-to-back with in_valid held high.
    set_key(K1);
    a0 = n_acc; p0 = n_pop;
    next_exp = C1_PT; ct_in = C1_CT; in_valid = 1'b1;
    wait_acc(a0 + 1);
    a1 = acc_edge;
    next_exp = B_PT; ct_in = B_CT;
    wait_ov();
    set_key(KB);
    wait_acc(a0 + 2);
    a2 = acc_edge;
    in_valid = 1'b0;
    chk("b2b_period", 128'(a2 - a1), 128'd12);
    wait_pop(p0 + 2, 1'b0);

    // Random keys and ciphertexts with random backpressure.
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) tick();
      run_block(key, ct, model_dec(ct, key), 1'b1);
    end

    tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes128_decrypt_iter.md
AES128_DECRYPT_ITER -- requirements
Module: aes128_decrypt_iter

Interface
REQ-001 The module SHALL have no parameters; block size 128 bits and 10 rounds are fixed.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port ct_in  input  128  ciphertext block, byte 0 in bits [127:120].
REQ-006 Port in_valid  input  1  ct_in is valid.
REQ-007 Port in_ready  output  1  the core can accept a block.
REQ-008 Port rk_sel  output  4  index (0..10) of the round key the core needs this cycle.
REQ-009 Port rk_in  input  128  round key rk_sel, driven combinationally by the external key store in the same cycle.
REQ-010 Port pt_out  output  128  recovered plaintext, registered.
REQ-011 Port out_valid  output  1  pt_out holds a completed block.
REQ-012 Port out_ready  input  1  downstream accepts pt_out.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ROUND, FINAL and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of in_ready.
REQ-016 In IDLE, rk_sel SHALL be 10; in all other states it SHALL equal the round counter.
REQ-017 Input accept occurs on an edge where in_ready and in_valid are both 1; at that edge the core SHALL load state <= ct_in ^ rk_in (rk10), set round counter = 9, and go to ROUND.
REQ-018 In ROUND, each edge SHALL compute state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_in) and decrement the counter.
REQ-019 ROUND SHALL go to FINAL on the edge where the counter goes from 1 to 0.
REQ-020 The FINAL edge SHALL compute pt_out <= InvSubBytes(InvShiftRows(state)) ^ rk_in (rk0), set out_valid=1, and go to DONE.
REQ-021 Latency SHALL be exactly 10 rising edges from the accept edge to the edge that sets out_valid.
REQ-022 In DONE, pt_out and out_valid SHALL stay stable until out_ready=1.
REQ-023 The DONE edge with out_ready=1 SHALL clear out_valid and go to IDLE; pt_out SHALL keep its last value.
REQ-024 in_valid SHALL be ignored outside IDLE; changes on ct_in after the accept edge SHALL NOT affect the result.
REQ-025 The minimum block period with out_ready tied high SHALL be 12 cycles: accept, 9 ROUND cycles, FINAL, DONE.
REQ-026 InvSubBytes SHALL use 16 instances of the team's 8-bit inv_sbox submodule.
REQ-027 InvMixColumns SHALL be combinational GF(2^8) arithmetic using polynomial 0x11B and coefficients 0e/0b/0d/09.
REQ-028 No datapath stage SHALL be shared across cycles, so there is one round per clock.

Reset
REQ-029 While rst_n=0, regardless of clk: state=IDLE, counter=0, datapath state=0, pt_out=0, out_valid=0.
REQ-030 The reset value of in_ready SHALL be 1, busy 0, and rk_sel 10.
REQ-031 Reset asserted mid-operation SHALL abort the block with no output produced; the first block after release SHALL decrypt correctly.

Verification
REQ-032 FIPS-197 C.1: key schedule from key 000102030405060708090a0b0c0d0e0f (rk1=d6aa74fdd2af72fadaa678f1d6ab76fe, rk10=13111d7fe3944a17f307a78b4d2b30c5), ct_in 69c4e0d86a7b0430d8cdb78070b4c55a -> pt_out 00112233445566778899aabbccddeeff, out_valid on the 10th edge after accept.
REQ-033 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct_in 3925841d02dc09fbdc118597196a0b32 -> pt_out 3243f6a8885a308d313198a2e0370734.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> pt_out and out_valid stable, in_ready=0; on out_ready=1, out_valid clears, and in_ready=1 on the next cycle.
REQ-035 Reset during ROUND with counter=5 -> all outputs at reset values immediately (asynchronously); after release, C.1 vector passes.
REQ-036 Pulse in_valid and randomize ct_in during ROUND -> ignored; C.1 result is unchanged.
REQ-037 Back-to-back C.1 then B with out_ready=1 and in_valid held -> both results correct, accept edges 12 cycles apart, rk_sel sequence 10,9,...,1,0 per block.
